// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel row writer.
//   state_t      : writer FSM encoding (IDLE=0, FILL=1, DONE=2)
//   *_DEF        : default geometry used by pixel_row_writer
package pixel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned PIX_W_DEF    = 10;
    localparam int unsigned ROW_PIX_DEF  = 28;
    localparam int unsigned NUM_ROWS_DEF = 28;
    localparam int unsigned SEL_BIT_DEF  = 5;

endpackage

// File: rtl/pixel_pos_counter.sv
// Column / row position counter for the pixel row writer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : zero col and row_sel (start of a frame)
//   advance     : one pixel accepted this cycle
//   col         : current column within the row
//   row_sel     : current row; holds at the last row once the frame wraps
//   row_wrap    : combinational strobe, advance on the last column
//   frame_wrap  : combinational strobe, advance on the last column of the last row
module pixel_pos_counter #(
    parameter int unsigned ROW_PIX  = 28,
    parameter int unsigned NUM_ROWS = 28,
    parameter int unsigned SEL_BIT  = 5,
    parameter int unsigned COL_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               advance,
    output logic [COL_W-1:0]   col,
    output logic [SEL_BIT-1:0] row_sel,
    output logic               row_wrap,
    output logic               frame_wrap
);

    localparam logic [COL_W-1:0]   COL_LAST = COL_W'(ROW_PIX - 1);
    localparam logic [SEL_BIT-1:0] ROW_LAST = SEL_BIT'(NUM_ROWS - 1);

    logic [COL_W-1:0]   col_q, col_d;
    logic [SEL_BIT-1:0] row_q, row_d;

    always_comb begin
        row_wrap   = advance && (col_q == COL_LAST);
        frame_wrap = row_wrap && (row_q == ROW_LAST);
        col_d      = col_q;
        row_d      = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (advance) begin
            if (row_wrap) begin
                col_d = '0;
                // The last row is held so Row_Sel still names it after the frame ends.
                if (!frame_wrap) begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col     = col_q;
    assign row_sel = row_q;

endmodule

// File: rtl/pixel_row_writer.sv
// Writes a raster-order pixel stream into a flat frame buffer, row by row.
// Optional feature: define PIXEL_WRITER_CLEAR_EN to zero the whole buffer when a
// frame starts; otherwise unwritten pixels keep their previous contents.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   Start        : begin a frame (honoured only in IDLE)
//   In_Valid     : In_Pixel is valid
//   In_Pixel     : incoming pixel
//   In_Ready     : pixel accepted this cycle when In_Valid is also high (FILL only)
//   Row_Sel      : current write row
//   Row_Done     : registered pulse after the last pixel of a row
//   Frame_Done   : registered pulse after the last pixel of the frame
//   Busy         : state is FILL
//   Buffer       : frame store, row r at [(r+1)*PIX_W*ROW_PIX-1 : r*PIX_W*ROW_PIX]
module pixel_row_writer
    import pixel_pkg::*;
#(
    parameter int unsigned PIX_W    = PIX_W_DEF,
    parameter int unsigned ROW_PIX  = ROW_PIX_DEF,
    parameter int unsigned NUM_ROWS = NUM_ROWS_DEF,
    parameter int unsigned SEL_BIT  = SEL_BIT_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               Start,
    input  logic                               In_Valid,
    input  logic [PIX_W-1:0]                   In_Pixel,
    output logic                               In_Ready,
    output logic [SEL_BIT-1:0]                 Row_Sel,
    output logic                               Row_Done,
    output logic                               Frame_Done,
    output logic                               Busy,
    output logic [PIX_W*ROW_PIX*NUM_ROWS-1:0]  Buffer
);

    localparam int unsigned BUF_W = PIX_W * ROW_PIX * NUM_ROWS;
    localparam int unsigned COL_W = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;
    localparam int unsigned IDX_W = (BUF_W > 1) ? $clog2(BUF_W) : 1;

    state_t             state_q, state_d;
    logic               start_fill;
    logic               handshake;
    logic               row_wrap, frame_wrap;
    logic [COL_W-1:0]   col;
    logic [IDX_W-1:0]   wr_bit;
    logic [BUF_W-1:0]   buffer_q, buffer_d;
    logic               row_done_q, frame_done_q;

    pixel_pos_counter #(
        .ROW_PIX  (ROW_PIX),
        .NUM_ROWS (NUM_ROWS),
        .SEL_BIT  (SEL_BIT),
        .COL_W    (COL_W)
    ) u_pos (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_fill),
        .advance    (handshake),
        .col        (col),
        .row_sel    (Row_Sel),
        .row_wrap   (row_wrap),
        .frame_wrap (frame_wrap)
    );

    always_comb begin
        state_d    = state_q;
        start_fill = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d    = FILL;
                    start_fill = 1'b1;
                end
            end
            FILL: begin
                if (frame_wrap) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign In_Ready  = (state_q == FILL);
    assign Busy      = (state_q == FILL);
    assign handshake = In_Valid && In_Ready;

    // Bit offset of the pixel at (Row_Sel, col).
    assign wr_bit = IDX_W'((ROW_PIX * 32'(Row_Sel) + 32'(col)) * PIX_W);

    always_comb begin
        buffer_d = buffer_q;
`ifdef PIXEL_WRITER_CLEAR_EN
        if (start_fill) begin
            buffer_d = '0;
        end
`endif
        // start_fill and handshake are exclusive: In_Ready is low in IDLE.
        if (handshake) begin
            buffer_d[wr_bit +: PIX_W] = In_Pixel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            buffer_q     <= '0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buffer_q     <= buffer_d;
            row_done_q   <= row_wrap;
            frame_done_q <= frame_wrap;
        end
    end

    assign Row_Done   = row_done_q;
    assign Frame_Done = frame_done_q;
    assign Buffer     = buffer_q;

endmodule

// File: doc/pixel_row_writer.md
PIXEL_ROW_WRITER -- requirements
Module: pixel_row_writer

Interface
REQ-001 SHALL have parameter PIX_W, default 10, meaning bits per pixel.
REQ-002 SHALL have parameter ROW_PIX, default 28, meaning pixels per row; PIX_W*ROW_PIX is the row width (280).
REQ-003 SHALL have parameter NUM_ROWS, default 28, meaning rows per frame.
REQ-004 SHALL have parameter SEL_BIT, default 5, meaning row-index width; NUM_ROWS <= 2**SEL_BIT.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning an asynchronous, active-low reset.
REQ-007 SHALL have port Start, input, 1, meaning begin frame capture.
REQ-008 SHALL have port In_Valid, input, 1, meaning In_Pixel is valid.
REQ-009 SHALL have port In_Pixel, input, PIX_W, meaning the incoming pixel in raster order.
REQ-010 SHALL have port In_Ready, output, 1, meaning the writer accepts a pixel this cycle.
REQ-011 SHALL have port Row_Sel, output, SEL_BIT, meaning the current write row.
REQ-012 SHALL have port Row_Done, output, 1, meaning a one-cycle pulse when a row completes.
REQ-013 SHALL have port Frame_Done, output, 1, meaning a one-cycle pulse when the frame completes.
REQ-014 SHALL have port Busy, output, 1, meaning the block is in FILL.
REQ-015 SHALL have port Buffer, output, PIX_W*ROW_PIX*NUM_ROWS, meaning the flat frame store; row r occupies bits [(r+1)*PIX_W*ROW_PIX-1 : r*PIX_W*ROW_PIX], the packing consumed by the row-select mux.

Function
REQ-016 SHALL implement an FSM with states IDLE, FILL and DONE.
REQ-017 SHALL move from IDLE to FILL on Start=1, zeroing the column counter and Row_Sel; Start in FILL or DONE SHALL be ignored.
REQ-018 SHALL drive In_Ready=1 only in FILL and 0 otherwise; a handshake is In_Valid&&In_Ready.
REQ-019 SHALL, on a handshake, write In_Pixel to Buffer bits [(Row_Sel*ROW_PIX+col)*PIX_W +: PIX_W] at the same edge and increment col; other bits SHALL hold.
REQ-020 SHALL, when a handshake occurs with col=ROW_PIX-1, wrap col to 0, pulse Row_Done next cycle, and increment Row_Sel.
REQ-021 SHALL, when a handshake occurs with col=ROW_PIX-1 and Row_Sel=NUM_ROWS-1, pulse both Row_Done and Frame_Done next cycle, enter DONE, and hold Row_Sel at NUM_ROWS-1.
REQ-022 SHALL stay in DONE for exactly one cycle, then return to IDLE; Buffer SHALL hold its contents until the next write.
REQ-023 SHALL hold all counters and Buffer when In_Valid=0 in FILL, so bubbles have no effect.
REQ-024 SHALL drive Busy=1 exactly while the state is FILL.
REQ-025 SHALL give a latency of one cycle from the handshake edge to the Buffer update being visible; the Row_Done and Frame_Done pulses are registered.

Reset
REQ-026 SHALL, on rst_n=0 at any time including mid-frame, immediately set the state to IDLE and drive Row_Sel, col, Row_Done, Frame_Done, Busy, In_Ready and Buffer to 0.
REQ-027 SHALL NOT resume a partial frame after reset; a new Start is required.

Configuration
REQ-028 SHALL, with PIXEL_WRITER_CLEAR_EN defined, zero the entire Buffer on the IDLE->FILL transition edge.
REQ-029 SHALL, without PIXEL_WRITER_CLEAR_EN, retain Buffer across frames and overwrite only the written pixels.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE=2'd0, FILL=2'd1, DONE=2'd2) and the default parameter constants in a shared package, pixel_pkg.
REQ-031 SHALL implement the counters in one sub-module, pixel_pos_counter, which provides col and Row_Sel, accepts an advance input, and outputs the row_wrap and frame_wrap strobes; the Buffer write decode SHALL stay in the top module.

Verification
REQ-032 SHALL test: reset, then Start, then 784 pixels with value=index mod 1024 and In_Valid held at 1 -> 28 Row_Done pulses, one Frame_Done on the cycle after pixel 783, and Buffer[9:0]=0 and Buffer[7839:7830]=783.
REQ-033 SHALL test: In_Valid toggling 1,0,1,0 through row 0 -> Row_Done only after the 28th accepted pixel, and bubbles do not advance col.
REQ-034 SHALL test: Start pulsed at pixel 100 of a frame -> ignored, Row_Sel=3 and col=16 unaffected.
REQ-035 SHALL test: rst_n deasserted after 300 pixels -> all outputs 0 at once and In_Ready=0 until the next Start.
REQ-036 SHALL test: two back-to-back frames, the second all 10'h3FF written only to row 0 and then reset -> with PIXEL_WRITER_CLEAR_EN, rows 1-27 are 0; without it, reset forces Buffer to 0, so run the test without the reset and rows 1-27 keep the frame-1 data.
REQ-037 SHALL test: Start and In_Valid asserted in the same IDLE cycle -> no pixel accepted that cycle (In_Ready=0) and the first write occurs in the first FILL cycle.
